// File: rtl/ei_axi4_rtl_pkg.sv
// Shared AXI4 types for the slave-side read/write engines.
// Burst, response and write-FSM encodings plus small burst helpers.
package ei_axi4_rtl_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ei_axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED/INCR/WRAP bursts.
// Shared by the write engine and the future read engine.
import ei_axi4_rtl_pkg::*;

module ei_axi4_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  burst_e                burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] total;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] base;

    // Legal WRAP lengths make total a power of two, so mod is a mask.
    always_comb begin
        bytes     = ADDR_WIDTH'(1) << size;
        total     = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        mask      = total - ADDR_WIDTH'(1);
        base      = addr & ~mask;
        next_addr = addr;
        unique case (burst)
            BURST_INCR: next_addr = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            BURST_WRAP: next_addr = base + ((addr + bytes - base) & mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/ei_axi4_slave_wr_engine.sv
// AXI4 slave write engine: one burst at a time, AW/W in, word writes
// out with one cycle of latency, single B response per burst.
import ei_axi4_rtl_pkg::*;

module ei_axi4_slave_wr_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [ID_WIDTH-1:0]           awid,
    input  logic [ADDR_WIDTH-1:0]         awaddr,
    input  logic [7:0]                    awlen,
    input  logic [2:0]                    awsize,
    input  logic [1:0]                    awburst,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic                          wlast,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [ID_WIDTH-1:0]           bid,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    output logic                          mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [DATA_WIDTH/8-1:0]       mem_wstrb
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    wr_state_e             state;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    burst_e                burst_q;
    logic [7:0]            cnt_q;
    logic                  err_q;
    logic                  aw_err_q;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] word;
    logic                  in_range;
    logic                  at_len;
    logic                  beat_end;
    logic                  beat_err;
    logic                  aw_err;

    ei_axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_comb begin
        word     = addr_q >> OFF_W;
        in_range = word < ADDR_WIDTH'(MEM_DEPTH);
        at_len   = cnt_q == len_q;
        beat_end = at_len || wlast;
        beat_err = err_q || !in_range || (wlast != at_len);
        aw_err   = (awburst == BURST_RSVD) ||
                   (awsize > 3'(OFF_W)) ||
                   ((awburst == BURST_WRAP) && !wrap_len_ok(awlen));
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= WR_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            aw_err_q  <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                WR_IDLE: begin
                    if (awready && awvalid) begin
                        id_q     <= awid;
                        addr_q   <= awaddr;
                        len_q    <= awlen;
                        size_q   <= awsize;
                        burst_q  <= burst_e'(awburst);
                        cnt_q    <= '0;
                        err_q    <= aw_err;
                        aw_err_q <= aw_err;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        state    <= WR_DATA;
                    end else begin
                        awready  <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (wvalid && wready) begin
                        // Out-of-range beats are dropped but the burst runs on.
                        mem_we    <= !aw_err_q && in_range;
                        mem_addr  <= word[IDX_W-1:0];
                        mem_wdata <= wdata;
                        mem_wstrb <= wstrb;
                        addr_q    <= next_addr;
                        cnt_q     <= cnt_q + 8'd1;
                        err_q     <= beat_err;
                        if (beat_end) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= beat_err ? RESP_SLVERR : RESP_OKAY;
                            state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= WR_IDLE;
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ei_axi4_slave_wr_engine.sv
// Randomized bench for ei_axi4_slave_wr_engine with a burst-level
// reference model of expected memory writes and B responses.
module tb_ei_axi4_slave_wr_engine;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int unsigned a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];

    ei_axi4_slave_wr_engine dut (
        .aclk      (aclk),
        .areset    (areset),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (!areset && mem_we)
            obs_q.push_back('{32'(mem_addr), mem_wdata, mem_wstrb});
    end

    // Drive one burst and check its writes and response against the model.
    task automatic run_burst(
        input logic [3:0]  id,
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst,
        input int          wlast_at,
        input int          bdelay,
        input logic [31:0] dbase,
        input bit          rand_strb,
        input string       nm
    );
        longint unsigned a, bytes, total, base;
        int nbeats, t;
        bit aw_err, err;
        logic [31:0] wd[256];
        logic [3:0]  ws[256];
        logic [1:0]  exp_resp;

        bytes  = longint'(1) << size;
        aw_err = (burst == 2'd3) || (bytes > 4) ||
                 (burst == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        nbeats = (wlast_at >= 0 && wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
        err    = aw_err || (wlast_at != int'(len));
        exp_q.delete();
        a = addr;
        for (int i = 0; i < nbeats; i++) begin
            wd[i] = dbase + 32'(i);
            ws[i] = rand_strb ? 4'($urandom) : 4'hF;
            if (a / 4 >= 1024)
                err = 1;
            else if (!aw_err)
                exp_q.push_back('{32'(a / 4), wd[i], ws[i]});
            if (burst == 2'd1) begin
                a = ((a / bytes) * bytes + bytes) % 64'd4294967296;
            end else if (burst == 2'd2 && !aw_err) begin
                total = (longint'(len) + 1) * bytes;
                base  = (a / total) * total;
                a     = base + (a + bytes - base) % total;
            end
        end
        exp_resp = err ? 2'd2 : 2'd0;

        @(posedge aclk);
        #1;
        obs_q.delete();
        awid = id; awaddr = addr; awlen = len;
        awsize = size; awburst = burst; awvalid = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge aclk);
            if (awready) break;
        end
        if (t == 50) begin
            failures++;
            $display("FAIL %s aw_timeout awready=%b required=1", nm, awready);
            awvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        awvalid = 1'b0;

        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (i == wlast_at);
            for (t = 0; t < 50; t++) begin
                @(negedge aclk);
                if (wready) break;
            end
            if (t == 50) begin
                failures++;
                $display("FAIL %s w_timeout beat=%0d wready=%b required=1", nm, i, wready);
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            @(posedge aclk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;

        bready = (bdelay == 0);
        for (t = 0; t < 50; t++) begin
            if (bvalid) break;
            @(negedge aclk);
        end
        checks++;
        if (t == 50) begin
            failures++;
            $display("FAIL %s b_timeout bvalid=%b required=1", nm, bvalid);
            bready = 1'b0;
            return;
        end
        if (bvalid) @(negedge aclk);
        checks++;
        if ({bid, bresp} !== {id, exp_resp}) begin
            failures++;
            $display("FAIL %s b_fields bid=%h bresp=%0d required bid=%h bresp=%0d",
                     nm, bid, bresp, id, exp_resp);
        end
        for (int k = 0; k < bdelay; k++) begin
            @(negedge aclk);
            checks++;
            if ({bvalid, bid, bresp} !== {1'b1, id, exp_resp}) begin
                failures++;
                $display("FAIL %s b_hold cyc=%0d bvalid=%b bid=%h bresp=%0d required 1/%h/%0d",
                         nm, k, bvalid, bid, bresp, id, exp_resp);
            end
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        checks++;
        if ({bvalid, awready} !== 2'b01) begin
            failures++;
            $display("FAIL %s b_done bvalid=%b awready=%b required 0/1", nm, bvalid, awready);
        end
        @(negedge aclk);

        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s write_count got=%0d required=%0d", nm, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] != exp_q[i]) begin
                failures++;
                $display("FAIL %s write%0d got a=%h d=%h s=%h required a=%h d=%h s=%h",
                         nm, i, obs_q[i].a, obs_q[i].d, obs_q[i].s,
                         exp_q[i].a, exp_q[i].d, exp_q[i].s);
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if ({awready, wready, bvalid, mem_we, bid, bresp, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            failures++;
            $display("FAIL reset_state aw=%b w=%b b=%b we=%b bid=%h bresp=%0d required all 0",
                     awready, wready, bvalid, mem_we, bid, bresp);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (awready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release awready=%b required=1", awready);
        end
    endtask

    task automatic test_incr();
        int unsigned ea[4] = '{32'h40, 32'h41, 32'h42, 32'h43};
        run_burst(4'h5, 32'h100, 8'd3, 3'd2, 2'd1, 3, 0, 32'hA0, 0, "incr");
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            checks++;
            if (obs_q[i].a !== ea[i] || obs_q[i].d !== 32'hA0 + 32'(i)) begin
                failures++;
                $display("FAIL incr_plan beat%0d got a=%h d=%h required a=%h d=%h",
                         i, obs_q[i].a, obs_q[i].d, ea[i], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_wrap();
        int unsigned ea[4] = '{32'h0E, 32'h0F, 32'h0C, 32'h0D};
        run_burst(4'h9, 32'h38, 8'd3, 3'd2, 2'd2, 3, 1, $urandom, 1, "wrap");
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            checks++;
            if (obs_q[i].a !== ea[i]) begin
                failures++;
                $display("FAIL wrap_plan beat%0d got a=%h required a=%h", i, obs_q[i].a, ea[i]);
            end
        end
    endtask

    task automatic test_fixed();
        run_burst(4'h2, 32'h20, 8'd2, 3'd2, 2'd0, 2, 0, 32'h1000, 1, "fixed");
    endtask

    task automatic test_errors();
        run_burst(4'h3, 32'h40, 8'd2, 3'd2, 2'd2, 2, 0, $urandom, 1, "wrap_len2");
        run_burst(4'h4, 32'h40, 8'd2, 3'd2, 2'd3, 2, 0, $urandom, 1, "burst_rsvd");
        run_burst(4'h6, 32'h40, 8'd1, 3'd3, 2'd1, 1, 0, $urandom, 1, "size_too_big");
        run_burst(4'h7, 32'h100, 8'd3, 3'd2, 2'd1, 1, 5, $urandom, 1, "early_wlast");
        run_burst(4'h8, 32'h100, 8'd1, 3'd2, 2'd1, -1, 0, $urandom, 1, "missing_wlast");
        run_burst(4'hA, 32'hFF8, 8'd3, 3'd2, 2'd1, 3, 0, $urandom, 1, "out_of_range");
    endtask

    task automatic test_reset_mid_burst();
        @(posedge aclk);
        #1;
        awid = 4'hC; awaddr = 32'h0; awlen = 8'd7;
        awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(negedge aclk);
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b1;
        wstrb = 4'hF;
        repeat (2) begin
            wdata = $urandom;
            @(posedge aclk);
            #1;
        end
        areset = 1'b1;
        #1;
        checks++;
        if ({awready, wready, bvalid, mem_we, bid, bresp, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            failures++;
            $display("FAIL reset_mid aw=%b w=%b b=%b we=%b bid=%h bresp=%0d required all 0",
                     awready, wready, bvalid, mem_we, bid, bresp);
        end
        wvalid = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            checks++;
            if (bvalid !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_after cyc=%0d bvalid=%b wready=%b required 0/0",
                         k, bvalid, wready);
            end
        end
        run_burst(4'hD, 32'h200, 8'd3, 3'd2, 2'd1, 3, 0, $urandom, 1, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] b;
            logic [7:0] l;
            logic [2:0] s;
            int wl;
            b = 2'($urandom_range(0, 3));
            s = 3'($urandom_range(0, 3));
            if (b == 2'd2)
                l = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 16)
                       : (1 << $urandom_range(1, 4)) - 1);
            else
                l = 8'($urandom_range(0, 9));
            wl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) - 1 : int'(l);
            run_burst(4'($urandom), 32'($urandom_range(0, 32'h1100)), l, s, b,
                      wl, $urandom_range(0, 3), $urandom, 1, $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++)
            run_burst(4'(n), 32'h300 + 32'(n * 16), 8'd3, 3'd2, 2'd1, 3, 0,
                      $urandom, 1, $sformatf("b2b%0d", n));
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_errors();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
